// File: rtl/mostrador_sequencia.sv
// Sequence presenter for the memory game: walks the sequence memory from
// address 0 to a latched limit, lighting each entry for T_ACESO cycles and
// then blanking the LEDs for T_APAGADO cycles. Signals completion with a pronto pulse.
module mostrador_sequencia #(
    parameter int unsigned T_ACESO   = 1000,
    parameter int unsigned T_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int unsigned T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int unsigned TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Enum codes double as the debug display codes
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        BUSCA   = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t         state_q, state_d;
    logic [TW-1:0]   timer, timer_d;
    logic [3:0]      limite_reg, limite_d;
    logic [3:0]      endereco_d, leds_d;
    logic            busy_c;

    // States in which the presenter owns the LEDs and parar is honoured
    always_comb begin
        busy_c = (state_q == BUSCA) || (state_q == ACESO) || (state_q == APAGADO);
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_d    = state_q;
        timer_d    = timer;
        limite_d   = limite_reg;
        endereco_d = endereco;
        leds_d     = leds;
        case (state_q)
            OCIOSO: begin
                leds_d = '0;
                if (iniciar) begin
                    limite_d   = limite;
                    endereco_d = '0;
                    timer_d    = '0;
                    state_d    = BUSCA;
                end
            end
            BUSCA: begin
                // Memory data for the current address is valid by now
                leds_d  = dado;
                timer_d = '0;
                state_d = ACESO;
            end
            ACESO: begin
                if (timer == TW'(T_ACESO - 1)) begin
                    leds_d  = '0;
                    timer_d = '0;
                    state_d = APAGADO;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            APAGADO: begin
                leds_d = '0;
                if (timer == TW'(T_APAGADO - 1)) begin
                    timer_d = '0;
                    // Equality before increment: address never wraps past 15
                    if (endereco == limite_reg) begin
                        state_d = FIM;
                    end else begin
                        endereco_d = endereco + 4'd1;
                        state_d    = BUSCA;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            FIM: begin
                leds_d  = '0;
                timer_d = '0;
                state_d = OCIOSO;
            end
            default: begin
                leds_d  = '0;
                timer_d = '0;
                state_d = OCIOSO;
            end
        endcase
        // Abort overrides normal progress while playing; address is kept
        if (parar && busy_c) begin
            state_d    = OCIOSO;
            leds_d     = '0;
            timer_d    = '0;
            endereco_d = endereco;
        end
    end

    // State, datapath and registered status outputs with synchronous reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= OCIOSO;
            timer      <= '0;
            limite_reg <= '0;
            endereco   <= '0;
            leds       <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
            db_estado  <= 4'd0;
        end else begin
            state_q    <= state_d;
            timer      <= timer_d;
            limite_reg <= limite_d;
            endereco   <= endereco_d;
            leds       <= leds_d;
            ocupado    <= (state_d == BUSCA) || (state_d == ACESO) || (state_d == APAGADO);
            pronto     <= (state_d == FIM);
            db_estado  <= state_d;
        end
    end

endmodule

// File: tb/tb_mostrador_sequencia.sv
// Directed bench for mostrador_sequencia with T_ACESO=4, T_APAGADO=2 (7-cycle period).
module tb_mostrador_sequencia;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];
    int n_cmp = 0;
    int n_err = 0;

    mostrador_sequencia #(.T_ACESO(4), .T_APAGADO(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Memory read port: data follows the registered address
    assign dado = rom[endereco];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk("start_state", db_estado, 4'd1);
        chk("start_addr", endereco, 4'd0);
        chk("start_ocupado", 4'(ocupado), 4'd1);
    endtask

    // Expected lit value / state for edge e after start (e>=1, before FIM)
    function automatic logic [3:0] exp_leds(input int e);
        int ph = (e - 1) % 7;
        return (ph < 4) ? rom[(e - 1) / 7] : 4'd0;
    endfunction

    function automatic logic [3:0] exp_state(input int e);
        int ph = (e - 1) % 7;
        return (ph < 4) ? 4'd2 : (ph < 6) ? 4'd3 : 4'd1;
    endfunction

    // Follows a started sequence of n entries through FIM and back to idle
    task automatic play(input int n, input bit inject);
        for (int e = 1; e < 7 * n; e++) begin
            step();
            if (inject && e == 6) iniciar = 1'b0;
            chk("play_leds", leds, exp_leds(e));
            chk("play_state", db_estado, exp_state(e));
            chk("play_addr", endereco, 4'(e / 7));
            chk("play_ocupado", 4'(ocupado), 4'd1);
            chk("play_pronto", 4'(pronto), 4'd0);
            if (inject && e == 5) begin
                iniciar = 1'b1;
                limite  = 4'd0;
            end
        end
        step();
        chk("fim_pronto", 4'(pronto), 4'd1);
        chk("fim_state", db_estado, 4'd4);
        chk("fim_ocupado", 4'(ocupado), 4'd0);
        chk("fim_leds", leds, 4'd0);
        chk("fim_addr", endereco, 4'(n - 1));
        step();
        chk("post_pronto", 4'(pronto), 4'd0);
        chk("post_state", db_estado, 4'd0);
        chk("post_addr", endereco, 4'(n - 1));
        step();
        chk("idle_pronto", 4'(pronto), 4'd0);
        chk("idle_leds", leds, 4'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(i);
        rom[0] = 4'h1; rom[1] = 4'h2; rom[2] = 4'h4; rom[3] = 4'h8; rom[15] = 4'hF;
        reset = 1'b0; iniciar = 1'b0; parar = 1'b0; limite = 4'd0;

        // Reset state
        step(); step();
        chk("rst_addr", endereco, 4'd0);
        chk("rst_leds", leds, 4'd0);
        chk("rst_ocupado", 4'(ocupado), 4'd0);
        chk("rst_pronto", 4'(pronto), 4'd0);
        chk("rst_state", db_estado, 4'd0);
        reset = 1'b1;
        step();
        chk("idle_state", db_estado, 4'd0);

        // Basic playback, four entries
        start(4'd3);
        play(4, 1'b0);

        // Single entry
        start(4'd0);
        play(1, 1'b0);

        // Full length, no wrap
        start(4'd15);
        play(16, 1'b0);

        // Abort while second entry is lit
        start(4'd3);
        for (int e = 1; e <= 8; e++) step();
        chk("abort_lit", leds, 4'd2);
        parar = 1'b1;
        step();
        parar = 1'b0;
        chk("abort_state", db_estado, 4'd0);
        chk("abort_leds", leds, 4'd0);
        chk("abort_ocupado", 4'(ocupado), 4'd0);
        chk("abort_addr", endereco, 4'd1);
        for (int i = 0; i < 30; i++) begin
            step();
            chk("abort_no_pronto", 4'(pronto), 4'd0);
        end
        start(4'd3);
        step();
        chk("restart_leds", leds, 4'd1);
        chk("restart_addr", endereco, 4'd0);
        for (int e = 2; e < 28; e++) step();
        step(); step(); step();

        // iniciar and limite changes during APAGADO of entry 0 are ignored
        start(4'd3);
        play(4, 1'b1);

        // Reset mid-ACESO, iniciar held during reset
        start(4'd3);
        step(); step();
        chk("mid_lit", leds, 4'd1);
        reset   = 1'b0;
        iniciar = 1'b1;
        step();
        chk("mrst_state", db_estado, 4'd0);
        chk("mrst_leds", leds, 4'd0);
        chk("mrst_addr", endereco, 4'd0);
        chk("mrst_ocupado", 4'(ocupado), 4'd0);
        chk("mrst_pronto", 4'(pronto), 4'd0);
        step();
        chk("mrst_hold_state", db_estado, 4'd0);
        reset   = 1'b1;
        iniciar = 1'b0;
        step();
        chk("mrst_after_state", db_estado, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
